// File: rtl/branch_target_buffer.sv
// Tagged direct-mapped branch target buffer with 2-bit direction counters.
// Ports: clk, RESET_N (async low); lk_pc -> lk_hit/lk_taken/lk_target
//   (combinational lookup); upd_valid/upd_pc/upd_taken/upd_target/
//   upd_mispred (resolved-branch writeback); flush (sync invalidate);
//   stat_lookups/stat_hits/stat_mispreds (built only with BTB_STATS_EN,
//   otherwise tied to 0).
module branch_target_buffer #(
  parameter int DBITS     = 32,
  parameter int INDEXBITS = 4,
  parameter int TAGBITS   = 8,
  parameter int INSTSIZE  = 4,
  parameter int CNTBITS   = 32
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [DBITS-1:0]   lk_pc,
  output logic               lk_hit,
  output logic               lk_taken,
  output logic [DBITS-1:0]   lk_target,
  input  logic               upd_valid,
  input  logic [DBITS-1:0]   upd_pc,
  input  logic               upd_taken,
  input  logic [DBITS-1:0]   upd_target,
  input  logic               upd_mispred,
  input  logic               flush,
  output logic [CNTBITS-1:0] stat_lookups,
  output logic [CNTBITS-1:0] stat_hits,
  output logic [CNTBITS-1:0] stat_mispreds
);

  localparam int ENTRIES = 1 << INDEXBITS;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAGBITS-1:0] r_tag    [ENTRIES];
  logic [DBITS-1:0]   r_target [ENTRIES];

  logic [INDEXBITS-1:0] w_lk_idx;
  logic [TAGBITS-1:0]   w_lk_tag;
  logic [INDEXBITS-1:0] w_up_idx;
  logic [TAGBITS-1:0]   w_up_tag;
  logic                 w_up_hit;
  logic                 w_unused;

  assign w_lk_idx = lk_pc[INDEXBITS+1:2];
  assign w_lk_tag = lk_pc[INDEXBITS+TAGBITS+1:INDEXBITS+2];
  assign w_up_idx = upd_pc[INDEXBITS+1:2];
  assign w_up_tag = upd_pc[INDEXBITS+TAGBITS+1:INDEXBITS+2];

  // Low PC bits and bits above the tag play no part in indexing.
  assign w_unused = ^{lk_pc, upd_pc, upd_mispred};

  // Valid gates the tag compare so unreset tags never leak out.
  assign lk_hit    = r_valid[w_lk_idx] &&
                     (r_tag[w_lk_idx] == w_lk_tag);
  assign lk_taken  = lk_hit && r_ctr[w_lk_idx][1];
  assign lk_target = lk_taken ? r_target[w_lk_idx]
                              : lk_pc + DBITS'(INSTSIZE);

  assign w_up_hit = r_valid[w_up_idx] &&
                    (r_tag[w_up_idx] == w_up_tag);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (flush) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      unique case (1'b1)
        w_up_hit && upd_taken: begin
          if (r_ctr[w_up_idx] != 2'b11)
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
        end
        w_up_hit && !upd_taken: begin
          if (r_ctr[w_up_idx] != 2'b00)
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
        end
        !w_up_hit && upd_taken: begin
          r_valid[w_up_idx] <= 1'b1;
          r_ctr[w_up_idx]   <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // On a taken hit the tag rewrite is a no-op, so one write path
  // serves both allocation and target refresh.
  always_ff @(posedge clk) begin
    if (!flush && upd_valid && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [CNTBITS-1:0] r_lookups;
  logic [CNTBITS-1:0] r_hits;
  logic [CNTBITS-1:0] r_mispreds;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lookups  <= '0;
      r_hits     <= '0;
      r_mispreds <= '0;
    end else begin
      if (r_lookups != '1)
        r_lookups <= r_lookups + CNTBITS'(1);
      if (lk_hit && r_hits != '1)
        r_hits <= r_hits + CNTBITS'(1);
      if (upd_valid && upd_mispred && r_mispreds != '1)
        r_mispreds <= r_mispreds + CNTBITS'(1);
    end
  end

  assign stat_lookups  = r_lookups;
  assign stat_hits     = r_hits;
  assign stat_mispreds = r_mispreds;
`else
  assign stat_lookups  = '0;
  assign stat_hits     = '0;
  assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: reset, allocate, train,
// alias, flush, async reset and statistics counters.
module tb_branch_target_buffer;

  logic        clk;
  logic        RESET_N;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispreds;

  int n_checks = 0;
  int n_errors = 0;

  branch_target_buffer dut (
    .clk           (clk),
    .RESET_N       (RESET_N),
    .lk_pc         (lk_pc),
    .lk_hit        (lk_hit),
    .lk_taken      (lk_taken),
    .lk_target     (lk_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispred   (upd_mispred),
    .flush         (flush),
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_mispreds (stat_mispreds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic tk,
                      input logic [31:0] tgt);
    lk_pc = pc;
    #1;
    check({tag, ".hit"}, 64'(lk_hit), 64'(hit));
    check({tag, ".taken"}, 64'(lk_taken), 64'(tk));
    check({tag, ".target"}, 64'(lk_target), 64'(tgt));
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  initial begin
    RESET_N     = 1'b1;
    lk_pc       = 32'h100;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    upd_mispred = 1'b0;
    flush       = 1'b0;
    #2 RESET_N  = 1'b0;
    #1;
    look("rst_in", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      look("rst_out", 32'h100 + 32'(4 * i), 1'b0, 1'b0,
           32'h104 + 32'(4 * i));
    end

    // Allocate 0x120; same-cycle lookup sees old contents.
    upd_valid  = 1'b1;
    upd_pc     = 32'h120;
    upd_taken  = 1'b1;
    upd_target = 32'h200;
    look("same_cyc", 32'h120, 1'b0, 1'b0, 32'h124);
    tick();
    upd_valid = 1'b0;
    look("alloc", 32'h120, 1'b1, 1'b1, 32'h200);

    // Train: 10 -> 11 (sat) -> 10 -> 01 -> 00 -> 01.
    for (int i = 0; i < 3; i++) upd(32'h120, 1'b1, 32'h200);
    upd(32'h120, 1'b0, 32'h0);
    look("nt1", 32'h120, 1'b1, 1'b1, 32'h200);
    upd(32'h120, 1'b0, 32'h0);
    look("nt2", 32'h120, 1'b1, 1'b0, 32'h124);
    upd(32'h120, 1'b0, 32'h0);
    look("nt3", 32'h120, 1'b1, 1'b0, 32'h124);
    upd(32'h120, 1'b1, 32'h208);
    look("from00", 32'h120, 1'b1, 1'b0, 32'h124);
    upd(32'h120, 1'b1, 32'h208);
    look("retgt", 32'h120, 1'b1, 1'b1, 32'h208);

    // Aliasing at idx 8, then a not-taken miss that must not allocate.
    upd(32'h520, 1'b1, 32'h300);
    look("evicted", 32'h120, 1'b0, 1'b0, 32'h124);
    look("alias", 32'h520, 1'b1, 1'b1, 32'h300);
    upd(32'h620, 1'b0, 32'h0);
    look("nt_miss", 32'h620, 1'b0, 1'b0, 32'h624);
    look("nt_keep", 32'h520, 1'b1, 1'b1, 32'h300);

    // Flush beats a same-cycle allocation.
    upd(32'h100, 1'b1, 32'h400);
    look("pre_fl", 32'h100, 1'b1, 1'b1, 32'h400);
    flush = 1'b1;
    upd(32'h140, 1'b1, 32'h500);
    flush = 1'b0;
    look("fl_140", 32'h140, 1'b0, 1'b0, 32'h144);
    look("fl_100", 32'h100, 1'b0, 1'b0, 32'h104);
    look("fl_520", 32'h520, 1'b0, 1'b0, 32'h524);

    // Asynchronous reset mid-cycle.
    upd(32'h120, 1'b1, 32'h200);
    look("pre_rst", 32'h120, 1'b1, 1'b1, 32'h200);
    RESET_N = 1'b0;
    #1;
    check("async_rst.hit", 64'(lk_hit), 64'd0);
    tick();
    RESET_N = 1'b1;
    look("post_rst", 32'h120, 1'b0, 1'b0, 32'h124);

    // Statistics: 10 edges, hits on edges 2..5, mispreds on 1 and 6.
    for (int c = 1; c <= 10; c++) begin
      lk_pc       = (c >= 2 && c <= 5) ? 32'h120 : 32'h100;
      upd_valid   = (c == 1 || c == 6);
      upd_pc      = 32'h120;
      upd_taken   = 1'b1;
      upd_target  = 32'h200;
      upd_mispred = (c == 1 || c == 6 || c == 7);
      tick();
    end
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
`ifdef BTB_STATS_EN
    check("stat_lookups", 64'(stat_lookups), 64'd10);
    check("stat_hits", 64'(stat_hits), 64'd4);
    check("stat_mispreds", 64'(stat_mispreds), 64'd2);
`else
    check("stat_lookups", 64'(stat_lookups), 64'd0);
    check("stat_hits", 64'(stat_hits), 64'd0);
    check("stat_mispreds", 64'(stat_mispreds), 64'd0);
`endif
    look("stat_entry", 32'h120, 1'b1, 1'b1, 32'h200);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, tagged branch target buffer (BTB) with per-entry 2-bit saturating direction counters.
- Replaces the untagged, always-taken, fixed 256-entry prediction array in the pipelined core.
- Fetch performs a combinational lookup on the current PC. The ALU stage writes back the resolved outcome one update per cycle.
- Also provides optional hit/mispredict statistics counters for performance tuning.

Parameters:
DBITS, 32, PC and target width.
INDEXBITS, 4, log2 of entry count; ENTRIES = 1 << INDEXBITS.
TAGBITS, 8, tag width taken from the PC above the index; INDEXBITS + TAGBITS + 2 <= DBITS.
INSTSIZE, 4, instruction size in bytes; the fall-through PC is pc + INSTSIZE.
CNTBITS, 32, statistics counter width (optional feature only).

Ports:
clk  in  1  clock; all state changes on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
lk_pc  in  DBITS  fetch-stage PC to look up.
lk_hit  out  1  valid entry whose tag matches lk_pc.
lk_taken  out  1  lk_hit and the entry counter >= 2.
lk_target  out  DBITS  lk_taken ? stored target : lk_pc + INSTSIZE.
upd_valid  in  1  resolved branch/jump present this cycle.
upd_pc  in  DBITS  PC of the resolved instruction.
upd_taken  in  1  actual direction.
upd_target  in  DBITS  actual taken target.
upd_mispred  in  1  the pipeline mispredicted this instruction (statistics only).
flush  in  1  synchronous invalidate-all.
stat_lookups, stat_hits, stat_mispreds  out  CNTBITS  statistics (optional feature).

Behaviour:
- Address fields:
  - idx = pc[INDEXBITS+1:2].
  - tag = pc[INDEXBITS+TAGBITS+1:INDEXBITS+2].
  - pc[1:0] is ignored.
- Storage per entry:
  - valid, 1 bit, async reset to 0.
  - ctr, 2 bits, async reset to 2'b01.
  - tag, TAGBITS, not reset.
  - target, DBITS, not reset.
- Lookup is purely combinational, with zero latency from lk_pc.
- Lookup outputs during and after reset:
  - While RESET_N is low, and after release until the first allocation, all valid bits are 0.
  - Therefore lk_hit=0, lk_taken=0 and lk_target=lk_pc+INSTSIZE.
- Update takes effect at the clock edge and is visible to lookup on the next cycle. A same-cycle lookup of the same index returns the pre-update contents (no bypass).
- Update rules when upd_valid=1:
  - Hit (valid and tag match), taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate by overwriting idx. Set valid=1, tag=upd tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change; not-taken branches are never allocated.
- Counter encoding:
  - 00 = strong not-taken.
  - 01 = weak not-taken.
  - 10 = weak taken.
  - 11 = strong taken.
  - Saturates at both ends, never wraps.
- flush=1: all valid bits clear and all ctr return to 01 at the edge. Flush has priority over a same-cycle update; that update is discarded.
- The direct-mapped conflict is resolved by replacement: an allocation evicts the previous entry at that index regardless of its state.
- Asserting RESET_N low mid-operation immediately clears valid and ctr. Tag and target keep their values but are ignored while valid=0.
- Target addition wraps modulo 2^DBITS.
- No X propagation is allowed onto lk_* outputs for any known lk_pc.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined:
  - Three CNTBITS counters, async reset to 0.
  - stat_lookups increments every cycle after reset.
  - stat_hits increments when lk_hit=1.
  - stat_mispreds increments when upd_valid & upd_mispred.
  - All three saturate at all-ones.
  - flush does not clear them.
- When undefined: the counters are not built and the stat_* outputs are driven constant 0.

Test Plan:
- Reset release with INDEXBITS=4 and lk_pc=0x100 -> lk_hit=0, lk_taken=0, lk_target=0x104. Repeat for 16 distinct PCs 0x100..0x13C; all miss.
- upd pc=0x120, taken=1, target=0x200 -> next cycle lk_pc=0x120 gives hit=1, taken=1, target=0x200. A same-cycle lookup of 0x120 still misses.
- Train 0x120 taken 3 times (ctr=11), then not-taken twice -> taken=0 after the second not-taken (ctr=01). Then not-taken once more -> ctr=00, and 0x120 still hits.
- Aliasing: allocate 0x120, then taken 0x520 with target 0x300 (same idx 8, different tag) -> 0x120 misses and 0x520 hits with target 0x300.
- flush asserted together with upd pc=0x140 taken -> next cycle 0x120 and 0x140 both miss. RESET_N pulsed low mid-run -> lk_hit drops to 0 asynchronously, before the next edge.
- BTB_STATS_EN: 10 lookup cycles, 4 hits, 2 upd_mispred -> stat_lookups=10, stat_hits=4, stat_mispreds=2. With the macro undefined all three read 0.
